ycbcr_frame_ctrl: RTL and testbench
===================================

Name: ycbcr_frame_ctrl

Overview:
- Frame-level sequencer that feeds an RGB pixel stream through the RGB→YCbCr colour-space converter.
- Accepts one frame of IMG_W×IMG_H pixels after a start pulse and drives the converter's enable as a global pipeline advance.
- Tracks valid and sideband flags alongside the converter latency and presents a valid/ready output stream with sof/eol/eof markers.
- Sits between the pixel source (DMA/sensor front end) and downstream filter stages.

Parameters:
- DATA_WIDTH, 8, bits per colour component.
- IMG_W, 640, pixels per line (≥2).
- IMG_H, 480, lines per frame (≥1).
- CONV_LAT, 1, converter latency in enabled cycles (1..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the frame's last output handshake.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_data  in  3*DATA_WIDTH  RGB pixel, R in [DW-1:0], G in [2DW-1:DW], B in [3DW-1:2DW].
- conv_enable  out  1  converter clock-enable (pipeline advance).
- conv_rgb  out  3*DATA_WIDTH  pixel to converter; equals s_data.
- conv_ycbcr  in  3*DATA_WIDTH  converter result; holds while conv_enable is low.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream ready.
- m_data  out  3*DATA_WIDTH  equals conv_ycbcr.
- m_sof  out  1  first pixel of the frame; qualified by m_valid.
- m_eol  out  1  last pixel of a line; qualified by m_valid.
- m_eof  out  1  last pixel of the frame; qualified by m_valid.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge), then in the next cycle:
  - state = IDLE.
  - busy, done, s_ready, m_valid, m_sof, m_eol, m_eof = 0.
  - conv_enable = 1.
  - x/y counters and the valid/sideband shift registers = 0.
  - Reset mid-frame abandons the frame and does not pulse done.
- Advance: adv = !m_valid || m_ready.
  - conv_enable = adv.
  - Valid and sideband shift registers (CONV_LAT stages) shift only when adv = 1.
- FSM states:
  - IDLE: s_ready = 0. On start, clear counters and go to RUN. Any s_valid is ignored.
  - RUN: s_ready = adv. A stage-0 valid bit is loaded with (s_valid && s_ready).
  - On each accepted pixel:
    - x increments.
    - At x = IMG_W-1, x wraps to 0 and y increments.
    - Sideband captured: sof = (x==0 && y==0), eol = (x==IMG_W-1), eof = eol && (y==IMG_H-1).
  - RUN → DRAIN on acceptance of the eof pixel.
  - DRAIN: s_ready = 0. Wait until the eof-tagged output handshakes (m_valid && m_ready && m_eof).
  - DRAIN → DONE_ST. DONE_ST asserts done for 1 cycle, then goes to IDLE.
- busy = (state != IDLE).
- start is ignored outside IDLE.
- start and rst in the same cycle: rst wins.
- Latency: a pixel accepted in cycle t appears on m_valid at t+CONV_LAT, provided m_ready stayed high.
- Backpressure: m_ready low with m_valid high freezes the converter and all shift registers. m_data and flags stay stable; no pixel is lost or duplicated.
- Bubbles: s_valid low in RUN inserts invalid stages; counters do not move.
- Sideband width is 3 bits per stage. There is no arithmetic on pixel data in this block.

Optional Feature:
- Macro: YCBCR_FRAME_CNT_EN.
- When defined:
  - Adds output frame_cnt (16 bits).
  - Reset value 0; increments in the cycle done pulses.
  - Wraps 0xFFFF → 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=2, CONV_LAT=1, m_ready=1, s_valid=1 continuous, start at cycle 2:
  - 8 outputs on consecutive cycles.
  - m_sof on output 0; m_eol on outputs 3 and 7; m_eof on output 7.
  - done one cycle after output 7's handshake; busy falls with done.
- Same config, m_ready toggled 1,0,0,1 repeatedly:
  - m_data and flags stable while stalled; all 8 pixels delivered in order, none duplicated.
  - conv_enable equals (!m_valid || m_ready) every cycle.
- s_valid=1 in IDLE with no start for 10 cycles:
  - s_ready=0 throughout, m_valid=0, counters unchanged.
- rst asserted after 5 accepted pixels:
  - Next cycle: state IDLE, m_valid=0, busy=0, no done pulse.
  - A new start then produces m_sof on the first output.
- start pulsed while busy mid-frame: ignored; frame completes normally with exactly one done.
- With YCBCR_FRAME_CNT_EN and 3 back-to-back frames: frame_cnt reads 1, 2, 3 after each done; returns to 0 after rst.

Source files
------------

// File: rtl/ycbcr_frame_ctrl_if.sv
// Signal bundle between the YCbCr frame sequencer and its source, converter and sink.
// The frame_cnt signal exists only when YCBCR_FRAME_CNT_EN is defined.
interface ycbcr_frame_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      s_valid;
  logic                      s_ready;
  logic [3*DATA_WIDTH-1:0]   s_data;
  logic                      conv_enable;
  logic [3*DATA_WIDTH-1:0]   conv_rgb;
  logic [3*DATA_WIDTH-1:0]   conv_ycbcr;
  logic                      m_valid;
  logic                      m_ready;
  logic [3*DATA_WIDTH-1:0]   m_data;
  logic                      m_sof;
  logic                      m_eol;
  logic                      m_eof;
`ifdef YCBCR_FRAME_CNT_EN
  logic [15:0]               frame_cnt;
`endif

  modport slave (
    input  start, s_valid, s_data, conv_ycbcr, m_ready,
    output busy, done, s_ready, conv_enable, conv_rgb,
           m_valid, m_data, m_sof, m_eol, m_eof
`ifdef YCBCR_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport master (
    output start, s_valid, s_data, conv_ycbcr, m_ready,
    input  busy, done, s_ready, conv_enable, conv_rgb,
           m_valid, m_data, m_sof, m_eol, m_eof
`ifdef YCBCR_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/ycbcr_frame_ctrl.sv
// Frame sequencer around an external RGB->YCbCr converter: pipeline advance,
// valid/sideband tracking, sof/eol/eof tagging. YCBCR_FRAME_CNT_EN adds frame_cnt.
module ycbcr_frame_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned CONV_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  ycbcr_frame_ctrl_if.slave    bus
);

  localparam int unsigned PW = 3 * DATA_WIDTH;
  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ST} state_t;

  typedef struct packed {
    logic eof;
    logic eol;
    logic sof;
  } sb_t;

  state_t              state, state_nxt;
  logic [XW-1:0]       x_cnt;
  logic [YW-1:0]       y_cnt;
  logic [CONV_LAT-1:0] vld_q;
  sb_t                 sb_q [CONV_LAT];
  sb_t                 sb_in;
  logic                busy_q, done_q;
  logic                adv, s_ready_c, accept, x_last, y_last, m_valid;
  logic [PW-1:0]       pix_c;

  assign m_valid = vld_q[CONV_LAT-1];
  assign adv     = !m_valid || bus.m_ready;
  assign x_last  = (x_cnt == XW'(IMG_W - 1));
  assign y_last  = (y_cnt == YW'(IMG_H - 1));

  // Sideband for the pixel being accepted this cycle
  always_comb begin
    sb_in     = '0;
    sb_in.sof = accept && (x_cnt == '0) && (y_cnt == '0);
    sb_in.eol = accept && x_last;
    sb_in.eof = accept && x_last && y_last;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready_c = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN: begin
        s_ready_c = adv;
        accept    = bus.s_valid && adv;
        if (accept && x_last && y_last) state_nxt = DRAIN;
      end
      DRAIN:   if (m_valid && bus.m_ready && sb_q[CONV_LAT-1].eof) state_nxt = DONE_ST;
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE_ST);
    end
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (state == IDLE && bus.start) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? '0 : y_cnt + YW'(1);
      end else begin
        x_cnt <= x_cnt + XW'(1);
      end
    end
  end

  // Valid/sideband delay line matching the converter, frozen on backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < CONV_LAT; i++) sb_q[i] <= '0;
    end else if (adv) begin
      vld_q[0] <= accept;
      sb_q[0]  <= sb_in;
      for (int unsigned i = 1; i < CONV_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        sb_q[i]  <= sb_q[i-1];
      end
    end
  end

`ifdef YCBCR_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                         frame_cnt_q <= '0;
    else if (state_nxt == DONE_ST)   frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign bus.frame_cnt = frame_cnt_q;
`endif

  assign pix_c           = bus.s_data;
  assign bus.conv_rgb    = pix_c;
  assign bus.conv_enable = adv;
  assign bus.s_ready     = s_ready_c;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.m_valid     = m_valid;
  assign bus.m_data      = bus.conv_ycbcr;
  assign bus.m_sof       = sb_q[CONV_LAT-1].sof;
  assign bus.m_eol       = sb_q[CONV_LAT-1].eol;
  assign bus.m_eof       = sb_q[CONV_LAT-1].eof;

endmodule

// File: tb/tb_ycbcr_frame_ctrl.sv
// Directed bench for ycbcr_frame_ctrl (4x2 frame, 1-cycle converter model).
// Frame counter checks are active when YCBCR_FRAME_CNT_EN is defined.
module tb_ycbcr_frame_ctrl;

  localparam logic [23:0] MASK = 24'h5A5A5A;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   src_idx = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   first_acc = -1;
  logic busy_at_done = 1'b0;
  logic s_hs;
  logic stall_prev = 1'b0;
  logic [23:0] prev_data;
  logic [2:0]  prev_flags;
  logic [23:0] out_data[$];
  logic [2:0]  out_flags[$];
  int          out_cyc[$];

  ycbcr_frame_ctrl_if #(.DATA_WIDTH(8)) bus();

  ycbcr_frame_ctrl #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(2), .CONV_LAT(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // One-stage converter model with clock enable
  always_ff @(posedge clk) if (bus.conv_enable) bus.conv_ycbcr <= bus.conv_rgb ^ MASK;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pix(input int k);
    return 24'h102030 + 24'(k) * 24'h010203;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample/check at negedge, advance, update source after the edge
  task automatic tick();
    @(negedge clk);
    chk("conv_enable", 32'(bus.conv_enable), 32'(!bus.m_valid || bus.m_ready));
    if (stall_prev) begin
      chk("stall_valid", 32'(bus.m_valid), 32'd1);
      chk("stall_data", 32'(bus.m_data), 32'(prev_data));
      chk("stall_flags", 32'({bus.m_sof, bus.m_eol, bus.m_eof}), 32'(prev_flags));
    end
    stall_prev = bus.m_valid && !bus.m_ready;
    prev_data  = bus.m_data;
    prev_flags = {bus.m_sof, bus.m_eol, bus.m_eof};
    if (bus.m_valid && bus.m_ready) begin
      out_data.push_back(bus.m_data);
      out_flags.push_back({bus.m_sof, bus.m_eol, bus.m_eof});
      out_cyc.push_back(cyc);
    end
    s_hs = bus.s_valid && bus.s_ready;
    if (s_hs && first_acc < 0) first_acc = cyc;
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = bus.busy;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_hs) src_idx++;
    bus.s_data = pix(src_idx);
  endtask

  task automatic run_frame(input bit stall, input bit mid_start);
    int d0;
    int n;
    d0 = done_cnt;
    src_idx = 0;
    first_acc = -1;
    bus.s_data = pix(0);
    out_data.delete(); out_flags.delete(); out_cyc.delete();
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 200 && done_cnt == d0; i++) begin
      bus.m_ready = stall ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      bus.start = mid_start && (i == 3);
      tick();
    end
    bus.start = 1'b0;
    bus.m_ready = 1'b1;
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("busy_at_done", 32'(busy_at_done), 32'd1);
    n = out_data.size();
    chk("n_outputs", 32'(n), 32'd8);
    for (int k = 0; k < n; k++) begin
      chk("out_data", 32'(out_data[k]), 32'(pix(k) ^ MASK));
      chk("out_flags", 32'(out_flags[k]), 32'({k == 0, k % 4 == 3, k == 7}));
    end
    if (n > 0) begin
      chk("done_after_last", 32'(done_cyc - out_cyc[n-1]), 32'd1);
      if (!stall) begin
        chk("consecutive", 32'(out_cyc[n-1] - out_cyc[0]), 32'(n - 1));
        chk("latency", 32'(out_cyc[0] - first_acc), 32'd1);
      end
    end
    tick();
    chk("busy_fall", 32'(bus.busy), 32'd0);
    chk("done_pulse_len", 32'(bus.done), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    chk("single_done", 32'(done_cnt - d0), 32'd1);
    chk("idle_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    bus.s_data = pix(0);
    tick(); tick();
    rst = 1'b0;
    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_flags", 32'({bus.m_sof, bus.m_eol, bus.m_eof}), 32'd0);
    chk("rst_conv_en", 32'(bus.conv_enable), 32'd1);
    chk("rst_x", 32'(dut.x_cnt), 32'd0);
    chk("rst_y", 32'(dut.y_cnt), 32'd0);
`ifdef YCBCR_FRAME_CNT_EN
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
`endif
    tick();

    // Continuous flow, then backpressure 1,0,0,1
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);

    // s_valid in IDLE without start
    bus.s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_s_ready", 32'(bus.s_ready), 32'd0);
      chk("idle_m_valid", 32'(bus.m_valid), 32'd0);
    end
    chk("idle_x", 32'(dut.x_cnt), 32'd0);
    chk("idle_y", 32'(dut.y_cnt), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Reset after 5 accepted pixels
    begin
      int d0;
      d0 = done_cnt;
      src_idx = 0;
      bus.s_data = pix(0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 50 && src_idx < 5; i++) tick();
      chk("mid_accepted", 32'(src_idx), 32'd5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
      chk("mid_rst_done", 32'(bus.done), 32'd0);
      for (int i = 0; i < 3; i++) tick();
      chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
      chk("mid_rst_idle", 32'(bus.busy), 32'd0);
    end
    run_frame(1'b0, 1'b0);

    // start pulsed while busy
    run_frame(1'b0, 1'b1);

    // Three back-to-back frames after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0, 1'b0);
`ifdef YCBCR_FRAME_CNT_EN
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(f + 1));
`endif
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
`ifdef YCBCR_FRAME_CNT_EN
    chk("frame_cnt_rst", 32'(bus.frame_cnt), 32'd0);
`endif
    chk("final_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
